// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues request-to-send,
// shifts one byte with odd parity out on device-generated clocks, then checks the ack.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 1200,
    parameter int TIMEOUT_CYCLES = 180000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk12,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    output logic       rx_inhibit
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FLT_W = $clog2(FILTER_LEN + 1);

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_RTS       = 3'd2,
        S_SHIFT     = 3'd3,
        S_ACK       = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    state_t           state;
    logic [8:0]       frame;
    logic [3:0]       bit_cnt;
    logic [INH_W-1:0] inh_cnt;
    logic [TO_W-1:0]  to_cnt;

    logic             clk_s1, clk_s2;
    logic             data_s1, data_s2;
    logic             clk_filt;
    logic [FLT_W-1:0] flt_cnt;
    logic             fall;

    // Synchronizers idle high so reset never fabricates a falling edge.
    always_ff @(posedge clk12) begin
        if (reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
            clk_filt <= 1'b1;
            flt_cnt  <= '0;
            fall     <= 1'b0;
        end else begin
            clk_s1  <= ps2_clk_in;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data_in;
            data_s2 <= data_s1;
            fall    <= 1'b0;
            if (clk_s2 != clk_filt) begin
                if (flt_cnt == FLT_LAST) begin
                    clk_filt <= clk_s2;
                    flt_cnt  <= '0;
                    fall     <= clk_filt;
                end else begin
                    flt_cnt <= flt_cnt + FLT_W'(1);
                end
            end else begin
                flt_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk12) begin
        if (reset) begin
            state       <= S_IDLE;
            frame       <= '0;
            bit_cnt     <= '0;
            inh_cnt     <= '0;
            to_cnt      <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tx_start) begin
                        frame       <= {~^tx_data, tx_data};
                        inh_cnt     <= '0;
                        ps2_clk_oe  <= 1'b1;
                        ps2_data_oe <= 1'b0;
                        tx_busy     <= 1'b1;
                        state       <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    // Clock release and start bit change on the same edge.
                    if (inh_cnt == INH_LAST) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b1;
                        bit_cnt     <= '0;
                        to_cnt      <= '0;
                        state       <= S_RTS;
                    end else begin
                        inh_cnt <= inh_cnt + INH_W'(1);
                    end
                end
                S_RTS, S_SHIFT, S_ACK, S_WAIT_IDLE: begin
                    if (to_cnt == TO_LAST) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_busy     <= 1'b0;
                        tx_error    <= 1'b1;
                        to_cnt      <= '0;
                        state       <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                        case (state)
                            S_RTS: begin
                                state <= S_SHIFT;
                            end
                            S_SHIFT: begin
                                // Falls 1..9 present data LSB-first then parity; fall 10 is the stop bit.
                                if (fall) begin
                                    if (bit_cnt == 4'd9) begin
                                        ps2_data_oe <= 1'b0;
                                        state       <= S_ACK;
                                    end else begin
                                        ps2_data_oe <= ~frame[bit_cnt];
                                        bit_cnt     <= bit_cnt + 4'd1;
                                    end
                                end
                            end
                            S_ACK: begin
                                if (fall) begin
                                    if (!data_s2) begin
                                        state <= S_WAIT_IDLE;
                                    end else begin
                                        tx_busy  <= 1'b0;
                                        tx_error <= 1'b1;
                                        to_cnt   <= '0;
                                        state    <= S_IDLE;
                                    end
                                end
                            end
                            S_WAIT_IDLE: begin
                                if (clk_filt && data_s2) begin
                                    tx_busy <= 1'b0;
                                    tx_done <= 1'b1;
                                    to_cnt  <= '0;
                                    state   <= S_IDLE;
                                end
                            end
                            default: begin
                                state <= S_IDLE;
                            end
                        endcase
                    end
                end
                default: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    tx_busy     <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

    assign rx_inhibit = tx_busy;

endmodule
